// File: rtl/bullet_pool_if.sv
// rtl/bullet_pool_if.sv - fire request, target and per-slot bullet state bundle for bullet_pool
interface bullet_pool_if #(
  parameter int NUM_BULLETS = 4
) ();
  localparam int HW = $clog2(NUM_BULLETS + 1);

  logic                     tick;
  logic                     attack;
  logic                     defend;
  logic signed [10:0]       xPlayer;
  logic signed [9:0]        yPlayer;
  logic signed [10:0]       xEnemy;
  logic signed [9:0]        yEnemy;
  logic                     isQ;
  logic [NUM_BULLETS*11-1:0] x;
  logic [NUM_BULLETS*10-1:0] y;
  logic [NUM_BULLETS-1:0]   isE;
  logic                     isHit;
  logic [HW-1:0]            hitCnt;
  logic                     ready;

  modport slave (
    input  tick, attack, defend, xPlayer, yPlayer, xEnemy, yEnemy, isQ,
    output x, y, isE, isHit, hitCnt, ready
  );

  modport master (
    output tick, attack, defend, xPlayer, yPlayer, xEnemy, yEnemy, isQ,
    input  x, y, isE, isHit, hitCnt, ready
  );
endinterface

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - fixed-slot projectile pool: spawn, travel, hit and exit per frame tick
package GamePkg;
  localparam int PLAYER_X       = 16;
  localparam int PLAYER_Y       = 4;
  localparam int SQUAT_PLAYER_Y = 12;
  localparam int BULLET_X       = 4;
  localparam int BULLET_Y       = 3;
  localparam int MAP_X          = 640;
endpackage

module bullet_pool
  import GamePkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int STEP_X      = 8,
  parameter int COOLDOWN    = 12,
  parameter int DIR         = 0
) (
  input  logic         clk,
  input  logic         rst,
  bullet_pool_if.slave bus
);
  localparam int HW = $clog2(NUM_BULLETS + 1);
  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic signed [11:0] STEP12 = 12'(STEP_X);
  localparam logic signed [11:0] PX12   = 12'(PLAYER_X);
  localparam logic signed [11:0] PY12   = 12'(PLAYER_Y);
  localparam logic signed [11:0] SQY12  = 12'(SQUAT_PLAYER_Y);
  localparam logic signed [11:0] BX12   = 12'(BULLET_X);
  localparam logic signed [11:0] BY12   = 12'(BULLET_Y);
  localparam logic signed [11:0] EDGE12 = 12'(MAP_X - BULLET_X);
  localparam logic signed [10:0] SPAWN11 = 11'(PLAYER_X + BULLET_X);
  localparam logic [CW-1:0]      COOL_LOAD = CW'(COOLDOWN);

  logic [NUM_BULLETS-1:0] isE_q, isE_d;
  logic signed [10:0]     x_q [NUM_BULLETS];
  logic signed [10:0]     x_d [NUM_BULLETS];
  logic signed [9:0]      y_q [NUM_BULLETS];
  logic signed [9:0]      y_d [NUM_BULLETS];
  logic [CW-1:0]          cool_q, cool_d;
  logic                   isHit_q, isHit_d;
  logic [HW-1:0]          hitCnt_q, hitCnt_d;

  logic signed [11:0]     x_new [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] hit, kill, free_slots, spawn_oh;
  logic signed [11:0]     target_y, x_enemy;
  logic signed [10:0]     spawn_x;
  logic                   fire;

  // Hit and exit tests run on the already-moved 12-bit position of every live slot.
  always_comb begin : hit_test
    logic signed [11:0] x_cur;
    logic signed [11:0] dy;
    x_cur    = '0;
    dy       = '0;
    hit      = '0;
    kill     = '0;
    x_enemy  = {bus.xEnemy[10], bus.xEnemy};
    target_y = {{2{bus.yEnemy[9]}}, bus.yEnemy} + (bus.isQ ? SQY12 : PY12);
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_cur    = {x_q[i][10], x_q[i]};
      x_new[i] = (DIR == 0) ? x_cur + STEP12 : x_cur - STEP12;
      dy       = {{2{y_q[i][9]}}, y_q[i]} - target_y;
      if (isE_q[i]) begin
        if ((dy <= BY12) && (dy >= -BY12) &&
            ((DIR == 0) ? (x_new[i] + BX12 > x_enemy - PX12)
                        : (x_new[i] - BX12 < x_enemy + PX12)))
          hit[i] = 1'b1;
        if (hit[i] || ((DIR == 0) ? (x_new[i] > EDGE12) : (x_new[i] < BX12)))
          kill[i] = 1'b1;
      end
    end
  end

  // Spawn picks from the registered alive flags, so a slot freed this tick stays empty until the next one.
  always_comb begin
    free_slots = ~isE_q;
    spawn_oh   = free_slots & ((~free_slots) + NUM_BULLETS'(1));
    fire       = bus.tick && bus.attack && !bus.defend && (cool_q == '0) && (|free_slots);
    spawn_x    = (DIR == 0) ? bus.xPlayer + SPAWN11 : bus.xPlayer - SPAWN11;
  end

  always_comb begin
    isE_d    = isE_q;
    x_d      = x_q;
    y_d      = y_q;
    cool_d   = cool_q;
    isHit_d  = 1'b0;
    hitCnt_d = '0;
    if (bus.tick) begin
      isE_d = isE_q & ~kill;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (isE_q[i])
          x_d[i] = x_new[i][10:0];
        if (fire && spawn_oh[i]) begin
          isE_d[i] = 1'b1;
          x_d[i]   = spawn_x;
          y_d[i]   = bus.yPlayer;
        end
        hitCnt_d = hitCnt_d + HW'(hit[i]);
      end
      if (fire)
        cool_d = COOL_LOAD;
      else if (cool_q != '0)
        cool_d = cool_q - CW'(1);
      isHit_d = |hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isE_q    <= '0;
      cool_q   <= '0;
      isHit_q  <= 1'b0;
      hitCnt_q <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      isE_q    <= isE_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cool_q   <= cool_d;
      isHit_q  <= isHit_d;
      hitCnt_q <= hitCnt_d;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
    assign bus.x[g*11 +: 11] = x_q[g];
    assign bus.y[g*10 +: 10] = y_q[g];
  end

  assign bus.isE    = isE_q;
  assign bus.isHit  = isHit_q;
  assign bus.hitCnt = hitCnt_q;
  assign bus.ready  = (cool_q == '0) && (|(~isE_q));
endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - scenario tasks plus randomized run against a slot-array model
module tb_bullet_pool;
  import GamePkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bullet_pool_if #(.NUM_BULLETS(4)) ia ();
  bullet_pool_if #(.NUM_BULLETS(4)) ib ();
  bullet_pool_if #(.NUM_BULLETS(2)) ic ();
  bullet_pool_if #(.NUM_BULLETS(3)) id ();

  localparam int A_STEP = 8;
  localparam int A_COOL = 12;
  localparam int R_NB   = 3;
  localparam int R_STEP = 6;
  localparam int R_COOL = 2;
  localparam int R_DIR  = 1;

  bullet_pool #(.NUM_BULLETS(4), .STEP_X(A_STEP), .COOLDOWN(A_COOL), .DIR(0)) u_a (.clk(clk), .rst(rst), .bus(ia));
  bullet_pool #(.NUM_BULLETS(4), .STEP_X(8), .COOLDOWN(3), .DIR(0)) u_b (.clk(clk), .rst(rst), .bus(ib));
  bullet_pool #(.NUM_BULLETS(2), .STEP_X(8), .COOLDOWN(0), .DIR(0)) u_c (.clk(clk), .rst(rst), .bus(ic));
  bullet_pool #(.NUM_BULLETS(R_NB), .STEP_X(R_STEP), .COOLDOWN(R_COOL), .DIR(R_DIR)) u_d (.clk(clk), .rst(rst), .bus(id));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    ia.tick = 0; ia.attack = 0; ia.defend = 0; ia.xPlayer = '0; ia.yPlayer = '0; ia.xEnemy = '0; ia.yEnemy = '0; ia.isQ = 0;
    ib.tick = 0; ib.attack = 0; ib.defend = 0; ib.xPlayer = '0; ib.yPlayer = '0; ib.xEnemy = '0; ib.yEnemy = '0; ib.isQ = 0;
    ic.tick = 0; ic.attack = 0; ic.defend = 0; ic.xPlayer = '0; ic.yPlayer = '0; ic.xEnemy = '0; ic.yEnemy = '0; ic.isQ = 0;
    id.tick = 0; id.attack = 0; id.defend = 0; id.xPlayer = '0; id.yPlayer = '0; id.xEnemy = '0; id.yEnemy = '0; id.isQ = 0;
  endtask

  task automatic do_reset();
    init_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ia.isE !== 4'b0) begin errors++; $display("FAIL reset_isE: got %b want 0000", ia.isE); end
    checks++; if (ia.x !== 44'b0) begin errors++; $display("FAIL reset_x: got %h want 0", ia.x); end
    checks++; if (ia.y !== 40'b0) begin errors++; $display("FAIL reset_y: got %h want 0", ia.y); end
    checks++; if (ia.isHit !== 1'b0 || ia.hitCnt !== 3'd0) begin errors++; $display("FAIL reset_hit: got %b/%0d want 0/0", ia.isHit, ia.hitCnt); end
    checks++; if (ia.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ia.ready); end
    checks++; if ({ib.ready, ic.ready, id.ready} !== 3'b111) begin errors++; $display("FAIL reset_ready_all: got %b want 111", {ib.ready, ic.ready, id.ready}); end
  endtask

  task automatic test_single_fire();
    int base;
    base = 100 + PLAYER_X + BULLET_X;
    do_reset();
    ia.xPlayer = 11'(100); ia.yPlayer = 10'(100); ia.yEnemy = 10'(400);
    ia.attack = 1; ia.tick = 1;
    step();
    ia.attack = 0;
    checks++; if (ia.isE !== 4'b0001) begin errors++; $display("FAIL fire_isE: got %b want 0001", ia.isE); end
    checks++; if (ia.x[0 +: 11] !== 11'(base)) begin errors++; $display("FAIL fire_x: got %0d want %0d", $signed(ia.x[0 +: 11]), base); end
    checks++; if (ia.y[0 +: 10] !== 10'(100)) begin errors++; $display("FAIL fire_y: got %0d want 100", $signed(ia.y[0 +: 10])); end
    checks++; if (ia.ready !== 1'b0) begin errors++; $display("FAIL fire_ready: got %b want 0", ia.ready); end
    step();
    checks++; if (ia.x[0 +: 11] !== 11'(base + A_STEP)) begin errors++; $display("FAIL move_x: got %0d want %0d", $signed(ia.x[0 +: 11]), base + A_STEP); end
    ia.tick = 0;
    step();
    step();
    checks++; if (ia.x[0 +: 11] !== 11'(base + A_STEP) || ia.isE !== 4'b0001) begin errors++; $display("FAIL hold_x: got %0d want %0d", $signed(ia.x[0 +: 11]), base + A_STEP); end
  endtask

  task automatic test_cooldown();
    int exp_mask;
    int base;
    base = 100 + PLAYER_X + BULLET_X;
    exp_mask = 0;
    do_reset();
    ib.xPlayer = 11'(100); ib.yPlayer = 10'(100); ib.yEnemy = 10'(400);
    ib.attack = 1; ib.tick = 1;
    for (int t = 0; t < 10; t++) begin
      step();
      if (t % 4 == 0) exp_mask = exp_mask | (1 << (t / 4));
      checks++; if (ib.isE !== 4'(exp_mask)) begin errors++; $display("FAIL cooldown_isE t=%0d: got %b want %b", t, ib.isE, 4'(exp_mask)); end
    end
    ib.attack = 0; ib.tick = 0;
    checks++; if (ib.x[0 +: 11] !== 11'(base + 9*8)) begin errors++; $display("FAIL cooldown_x0: got %0d want %0d", $signed(ib.x[0 +: 11]), base + 9*8); end
    checks++; if (ib.x[11 +: 11] !== 11'(base + 5*8)) begin errors++; $display("FAIL cooldown_x1: got %0d want %0d", $signed(ib.x[11 +: 11]), base + 5*8); end
    checks++; if (ib.x[22 +: 11] !== 11'(base + 8)) begin errors++; $display("FAIL cooldown_x2: got %0d want %0d", $signed(ib.x[22 +: 11]), base + 8); end
  endtask

  task automatic test_full_pool();
    int base;
    base = 100 + PLAYER_X + BULLET_X;
    do_reset();
    ic.xPlayer = 11'(100); ic.yPlayer = 10'(100); ic.yEnemy = 10'(400);
    ic.attack = 1; ic.tick = 1;
    step();
    checks++; if (ic.isE !== 2'b01 || ic.ready !== 1'b1) begin errors++; $display("FAIL full_first: got %b/%b want 01/1", ic.isE, ic.ready); end
    step();
    checks++; if (ic.isE !== 2'b11 || ic.ready !== 1'b0) begin errors++; $display("FAIL full_second: got %b/%b want 11/0", ic.isE, ic.ready); end
    step();
    checks++; if (ic.isE !== 2'b11) begin errors++; $display("FAIL full_drop_isE: got %b want 11", ic.isE); end
    checks++; if (ic.x[0 +: 11] !== 11'(base + 16) || ic.x[11 +: 11] !== 11'(base + 8)) begin errors++; $display("FAIL full_drop_x: got %0d,%0d want %0d,%0d", $signed(ic.x[0 +: 11]), $signed(ic.x[11 +: 11]), base + 16, base + 8); end
    ic.attack = 0; ic.tick = 0;
  endtask

  task automatic test_exit();
    int sp0;
    sp0 = MAP_X - BULLET_X - 16;
    do_reset();
    ic.yPlayer = 10'(50); ic.yEnemy = 10'(400);
    ic.attack = 1; ic.tick = 1;
    ic.xPlayer = 11'(sp0 - PLAYER_X - BULLET_X);
    step();
    ic.xPlayer = 11'(0);
    step();
    checks++; if (ic.isE !== 2'b11 || ic.x[11 +: 11] !== 11'(PLAYER_X + BULLET_X)) begin errors++; $display("FAIL exit_setup: got %b/%0d want 11/%0d", ic.isE, $signed(ic.x[11 +: 11]), PLAYER_X + BULLET_X); end
    ic.xPlayer = 11'(300);
    step();
    checks++; if (ic.isE !== 2'b11 || ic.x[0 +: 11] !== 11'(MAP_X - BULLET_X)) begin errors++; $display("FAIL exit_edge: got %b/%0d want 11/%0d", ic.isE, $signed(ic.x[0 +: 11]), MAP_X - BULLET_X); end
    step();
    checks++; if (ic.isE !== 2'b10 || ic.isHit !== 1'b0) begin errors++; $display("FAIL exit_kill: got %b/%b want 10/0", ic.isE, ic.isHit); end
    step();
    checks++; if (ic.isE !== 2'b11 || ic.x[0 +: 11] !== 11'(300 + PLAYER_X + BULLET_X) || ic.isHit !== 1'b0) begin errors++; $display("FAIL exit_refill: got %b/%0d want 11/%0d", ic.isE, $signed(ic.x[0 +: 11]), 300 + PLAYER_X + BULLET_X); end
    ic.attack = 0; ic.tick = 0;
  endtask

  task automatic test_double_hit();
    int base, aligned, exp_k, got_k;
    base = 100 + PLAYER_X + BULLET_X;
    aligned = base + (A_COOL + 1) * A_STEP;
    exp_k = 1;
    while (aligned + exp_k * A_STEP + BULLET_X <= 300 - PLAYER_X) exp_k++;
    do_reset();
    ia.xPlayer = 11'(100); ia.yPlayer = 10'(100); ia.xEnemy = 11'(300); ia.yEnemy = 10'(100 - PLAYER_Y);
    ia.attack = 1; ia.tick = 1;
    step();
    ia.attack = 0;
    for (int t = 1; t <= A_COOL; t++) begin
      step();
      if (t == A_COOL - 1) begin
        checks++; if (ia.ready !== 1'b0) begin errors++; $display("FAIL dh_cool_busy: got %b want 0", ia.ready); end
      end
    end
    checks++; if (ia.ready !== 1'b1 || ia.isE !== 4'b0001) begin errors++; $display("FAIL dh_cool_done: got %b/%b want 1/0001", ia.ready, ia.isE); end
    ia.xPlayer = 11'(aligned - PLAYER_X - BULLET_X);
    ia.attack = 1;
    step();
    ia.attack = 0;
    checks++; if (ia.isE !== 4'b0011 || ia.x[0 +: 11] !== 11'(aligned) || ia.x[11 +: 11] !== 11'(aligned)) begin errors++; $display("FAIL dh_align: got %b %0d %0d want 0011 %0d", ia.isE, $signed(ia.x[0 +: 11]), $signed(ia.x[11 +: 11]), aligned); end
    got_k = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ia.isHit === 1'b1) begin
        got_k = k;
        break;
      end
    end
    checks++; if (got_k != exp_k) begin errors++; $display("FAIL dh_tick: got %0d want %0d", got_k, exp_k); end
    checks++; if (ia.hitCnt !== 3'd2 || ia.isE !== 4'b0) begin errors++; $display("FAIL dh_count: got %0d/%b want 2/0000", ia.hitCnt, ia.isE); end
    ia.tick = 0;
    step();
    checks++; if (ia.isHit !== 1'b0 || ia.hitCnt !== 3'd0) begin errors++; $display("FAIL dh_pulse: got %b/%0d want 0/0", ia.isHit, ia.hitCnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ia.xPlayer = 11'(100); ia.yPlayer = 10'(100); ia.yEnemy = 10'(400);
    ia.attack = 1; ia.tick = 1;
    step();
    ia.attack = 0;
    step();
    step();
    rst = 1; ia.attack = 1;
    step();
    rst = 0; ia.attack = 0; ia.tick = 0;
    checks++; if (ia.isE !== 4'b0 || ia.x !== 44'b0 || ia.y !== 40'b0) begin errors++; $display("FAIL midrst_state: got %b %h %h want 0", ia.isE, ia.x, ia.y); end
    checks++; if (ia.isHit !== 1'b0 || ia.hitCnt !== 3'd0 || ia.ready !== 1'b1) begin errors++; $display("FAIL midrst_out: got %b/%0d/%b want 0/0/1", ia.isHit, ia.hitCnt, ia.ready); end
  endtask

  task automatic test_random();
    bit m_alive [R_NB];
    int m_x [R_NB];
    int m_y [R_NB];
    int m_cool, m_cnt, sel, nx, ty, d, mask;
    bit m_hit, tk, at, df, q, xh, yv, off, any_free, m_ready;
    int xp, yp, xe, ye;
    do_reset();
    for (int i = 0; i < R_NB; i++) begin m_alive[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    m_cool = 0;
    yp = 120;
    for (int n = 0; n < 500; n++) begin
      tk = ($urandom_range(0, 3) != 0);
      at = ($urandom_range(0, 9) < 6);
      df = ($urandom_range(0, 9) < 2);
      q  = 1'($urandom_range(0, 1));
      xp = $urandom_range(0, 300);
      xe = int'($urandom_range(0, 400)) - 100;
      ye = yp + int'($urandom_range(0, 24)) - 16;
      id.tick = tk; id.attack = at; id.defend = df; id.isQ = q;
      id.xPlayer = 11'(xp); id.yPlayer = 10'(yp); id.xEnemy = 11'(xe); id.yEnemy = 10'(ye);
      m_cnt = 0;
      if (tk) begin
        sel = -1;
        for (int i = R_NB - 1; i >= 0; i--) if (!m_alive[i]) sel = i;
        ty = ye + (q ? SQUAT_PLAYER_Y : PLAYER_Y);
        for (int i = 0; i < R_NB; i++) begin
          if (m_alive[i]) begin
            nx = m_x[i] + (R_DIR != 0 ? -R_STEP : R_STEP);
            d = m_y[i] - ty;
            if (d < 0) d = -d;
            yv = (d <= BULLET_Y);
            xh = (R_DIR != 0) ? (nx - BULLET_X < xe + PLAYER_X) : (nx + BULLET_X > xe - PLAYER_X);
            off = (R_DIR != 0) ? (nx < BULLET_X) : (nx > MAP_X - BULLET_X);
            if (xh && yv) m_cnt++;
            if ((xh && yv) || off) m_alive[i] = 0;
            m_x[i] = nx;
          end
        end
        if (at && !df && m_cool == 0 && sel >= 0) begin
          m_alive[sel] = 1;
          m_x[sel] = xp + (R_DIR != 0 ? -(PLAYER_X + BULLET_X) : (PLAYER_X + BULLET_X));
          m_y[sel] = yp;
          m_cool = R_COOL;
        end else if (m_cool > 0) begin
          m_cool--;
        end
      end
      m_hit = (m_cnt > 0);
      mask = 0;
      any_free = 0;
      for (int i = 0; i < R_NB; i++) begin
        if (m_alive[i]) mask = mask | (1 << i);
        else any_free = 1;
      end
      m_ready = (m_cool == 0) && any_free;
      step();
      checks++; if (id.isE !== 3'(mask)) begin errors++; $display("FAIL rand_isE n=%0d: got %b want %b", n, id.isE, 3'(mask)); end
      checks++; if (id.isHit !== m_hit || id.hitCnt !== 2'(m_cnt)) begin errors++; $display("FAIL rand_hit n=%0d: got %b/%0d want %b/%0d", n, id.isHit, id.hitCnt, m_hit, m_cnt); end
      checks++; if (id.ready !== m_ready) begin errors++; $display("FAIL rand_ready n=%0d: got %b want %b", n, id.ready, m_ready); end
      for (int i = 0; i < R_NB; i++) begin
        if (m_alive[i]) begin
          checks++;
          if (id.x[i*11 +: 11] !== 11'(m_x[i]) || id.y[i*10 +: 10] !== 10'(m_y[i])) begin
            errors++;
            $display("FAIL rand_pos n=%0d slot=%0d: got %0d,%0d want %0d,%0d", n, i, $signed(id.x[i*11 +: 11]), $signed(id.y[i*10 +: 10]), m_x[i], m_y[i]);
          end
        end
      end
    end
    init_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    init_inputs();
    test_reset();
    test_single_fire();
    test_cooldown();
    test_full_pool();
    test_exit();
    test_double_hit();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 The block SHALL have parameter NUM_BULLETS, default 4, meaning number of concurrent bullet slots (range 1..8).
REQ-002 The block SHALL have parameter STEP_X, default 8, meaning unsigned pixels travelled per tick.
REQ-003 The block SHALL have parameter COOLDOWN, default 12, meaning ticks between successive fires (0 = no cooldown).
REQ-004 The block SHALL have parameter DIR, default 0, meaning travel direction (0 = +x toward the right edge, 1 = -x toward the left edge).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port tick, input, 1, the frame-advance strobe; all state except outputs isHit and hitCnt changes only on clk edges with tick=1.
REQ-008 The block SHALL have ports attack and defend, input, 1 each, the fire request and the fire inhibit.
REQ-009 The block SHALL have ports xPlayer (signed 11) and yPlayer (signed 10), input, the shooter centre.
REQ-010 The block SHALL have ports xEnemy (signed 11), yEnemy (signed 10) and isQ (1), input, the target centre and its squat flag.
REQ-011 The block SHALL have ports x (output, signed 11 x NUM_BULLETS, packed) and y (output, signed 10 x NUM_BULLETS, packed), the per-slot bullet centres.
REQ-012 The block SHALL have port isE, output, NUM_BULLETS, the per-slot alive flags.
REQ-013 The block SHALL have port isHit, output, 1, a one-cycle pulse signalling at least one hit.
REQ-014 The block SHALL have port hitCnt, output, clog2(NUM_BULLETS+1), the number of hits in that tick.
REQ-015 The block SHALL have port ready, output, 1, high when cooldown is 0 and at least one slot is free.

Function
REQ-016 The block SHALL use the GamePkg constants PLAYER_X, PLAYER_Y, SQUAT_PLAYER_Y, BULLET_X, BULLET_Y and MAP_X.
REQ-017 The block SHALL perform all position arithmetic at 12 bits signed and SHALL store x truncated to 11 bits; spawn and kill tests SHALL use the 12-bit values.
REQ-018 The block SHALL move each alive slot by +STEP_X on a tick when DIR=0 and by -STEP_X when DIR=1; the y of a slot SHALL remain fixed after spawn.
REQ-019 The block SHALL evaluate hit tests on the moved position: target Y is yEnemy+SQUAT_PLAYER_Y when isQ=1, else yEnemy+PLAYER_Y; y-overlap is |y - targetY| <= BULLET_Y.
REQ-020 The block SHALL detect an x-hit when DIR=0 and xNew+BULLET_X > xEnemy-PLAYER_X, and when DIR=1 and xNew-BULLET_X < xEnemy+PLAYER_X.
REQ-021 The block SHALL clear the isE of a slot on that tick when both x-hit and y-overlap are true.
REQ-022 The block SHALL clear the isE of a slot with no hit when DIR=0 and xNew > MAP_X-BULLET_X, or when DIR=1 and xNew < BULLET_X.
REQ-023 The block SHALL count a hit exactly once even when the off-screen condition also holds.
REQ-024 The block SHALL fire on a tick when attack=1, defend=0, the cooldown counter is 0 and a slot is free; it SHALL select the lowest-index slot whose registered isE is 0.
REQ-025 The block SHALL set a fired slot to isE=1, x = xPlayer±(PLAYER_X+BULLET_X) (sign per DIR) and y = yPlayer; the slot SHALL NOT move or hit-test on its spawn tick.
REQ-026 The block SHALL NOT reuse, on the same tick, a slot freed by a hit or an exit on that tick.
REQ-027 The block SHALL fire at most one bullet per tick.
REQ-028 The block SHALL load the cooldown counter with COOLDOWN on a fire, and SHALL decrement it by 1 on each other tick while it is nonzero.
REQ-029 The block SHALL leave the counter and the slots untouched when a fire is blocked by defend, cooldown or a full pool; the request SHALL NOT be queued.
REQ-030 The block SHALL register isHit and hitCnt on the tick edge; they SHALL be valid for exactly one cycle after that edge and 0 otherwise.
REQ-031 The block SHALL hold all state when tick=0.

Reset
REQ-032 The block SHALL, with rst=1 at a clk edge, clear all isE, x, y, the cooldown counter, isHit and hitCnt to 0, taking priority over tick.
REQ-033 The block SHALL drive ready=1 after reset, and SHALL discard bullets in flight when reset is applied mid-operation.

Verification
REQ-034 The bench SHALL apply, with DIR=0 and xPlayer=100, a held attack for 1 tick -> slot0 isE=1 with x=100+PLAYER_X+BULLET_X, and after the next tick x is +8.
REQ-035 The bench SHALL apply, with COOLDOWN=3, attack held for 10 ticks -> fires on ticks 0, 4 and 8 into slots 0, 1 and 2.
REQ-036 The bench SHALL apply, with NUM_BULLETS=2, COOLDOWN=0 and attack held -> slots 0 and 1 fill, ready=0, and the third request is dropped with no slot changed.
REQ-037 The bench SHALL place the enemy so that two bullets cross its edge on the same tick -> one-cycle isHit=1, hitCnt=2, both isE=0.
REQ-038 The bench SHALL fly a bullet near MAP_X-BULLET_X with the enemy off-axis -> it is killed on the first tick with xNew > MAP_X-BULLET_X, isHit stays 0, and the slot is refilled on the following tick.
REQ-039 The bench SHALL assert rst mid-flight while tick=1 -> all outputs are 0 next cycle and ready=1.
